// File: rtl/multicycle_seq_if.sv
// Unified instruction/data memory port between the multi-cycle sequencer (master)
// and the memory (slave).
interface multicycle_seq_if;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, addr_sel, input mem_ready, mem_rdata);
    modport slave  (input mem_req, mem_we, addr_sel, output mem_ready, mem_rdata);
endinterface

// File: rtl/multicycle_seq.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving the shared datapath.
// Optional PERF_CNT_EN adds cycle_cnt/instr_cnt performance counters.
module multicycle_seq #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    multicycle_seq_if.master        bus,
    input  logic                    alu_zero,
    input  logic                    flag_cond,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic [1:0]              pc_src,
    output logic                    Reg2Loc,
    output logic                    ALUSrc,
    output logic [1:0]              ALUOp,
    output logic                    RegWrite,
    output logic                    MemToReg,
    output logic                    FlagWrite,
    output logic                    trap,
    output logic                    retire,
    output logic [2:0]              state
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]             cycle_cnt,
    output logic [31:0]             instr_cnt
`endif
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    logic [31:0]     ir;
    logic [2:0]      nextState;
    logic [TO_W-1:0] toCnt;
    logic            memWait, toHit;
    logic            isB, isCbz, isBcond, isMovz, isCmp, isSubi, isAdd, isLdur, isStur, legal;
    logic            unusedIrLow;

    assign isCbz   = ir[31:24] == 8'b10110100;
    assign isB     = ir[31:26] == 6'b000101;
    assign isBcond = ir[31:24] == 8'b01010100;
    assign isMovz  = ir[31:23] == 9'b110100101;
    assign isCmp   = ir[31:24] == 8'b11101011;
    assign isSubi  = ir[31:23] == 9'b110100010;
    assign isAdd   = ir[31:21] == 11'b10001011000;
    assign isLdur  = ir[31:21] == 11'b11111000010;
    assign isStur  = ir[31:21] == 11'b11111000000;
    assign legal   = isCbz | isB | isBcond | isMovz | isCmp | isSubi | isAdd | isLdur | isStur;
    assign unusedIrLow = ^ir[20:0];

    assign trap    = (state == S_TRAP);
    assign memWait = bus.mem_req && !bus.mem_ready;

    // toHit fires on the wait cycle that brings the count up to MEM_TIMEOUT;
    // a ready in that same cycle masks it through memWait.
    generate
        if (MEM_TIMEOUT > 0) begin : gTimeout
            assign toHit = memWait && (toCnt == TO_W'(MEM_TIMEOUT - 1));
        end else begin : gNoTimeout
            assign toHit = 1'b0;
        end
    endgenerate

    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   nextState = S_FETCH;
            S_FETCH:  if (bus.mem_ready) nextState = S_DECODE;
                      else if (toHit)    nextState = S_TRAP;
            S_DECODE: nextState = legal ? S_EXEC : S_TRAP;
            S_EXEC:   if (isAdd || isSubi || isMovz) nextState = S_WB;
                      else if (isLdur || isStur)     nextState = S_MEM;
                      else                           nextState = S_FETCH;
            S_MEM:    if (bus.mem_ready) nextState = isStur ? S_FETCH : S_WB;
                      else if (toHit)    nextState = S_TRAP;
            S_WB:     nextState = S_FETCH;
            default:  nextState = S_TRAP;
        endcase
    end

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        Reg2Loc      = 1'b0;
        ALUSrc       = 1'b0;
        ALUOp        = 2'b00;
        RegWrite     = 1'b0;
        MemToReg     = 1'b0;
        FlagWrite    = 1'b0;
        retire       = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                ir_write    = bus.mem_ready;
                pc_write    = bus.mem_ready;
            end
            S_DECODE: Reg2Loc = isCbz || isStur;
            S_EXEC: begin
                // Branch offsets are applied to the already-advanced PC by the datapath.
                if (isB)     begin pc_write = 1'b1; pc_src = 2'b01; retire = 1'b1; end
                if (isCbz)   begin ALUOp = 2'b01; Reg2Loc = 1'b1; pc_write = alu_zero;
                                   pc_src = 2'b01; retire = 1'b1; end
                if (isBcond) begin pc_write = flag_cond; pc_src = 2'b01; retire = 1'b1; end
                if (isCmp)   begin ALUOp = 2'b01; FlagWrite = 1'b1; retire = 1'b1; end
                if (isAdd)   ALUOp = 2'b10;
                if (isSubi)  begin ALUOp = 2'b10; ALUSrc = 1'b1; end
                if (isMovz || isLdur || isStur) ALUSrc = 1'b1;
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = isStur;
                retire       = isStur && bus.mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemToReg = isLdur;
                retire   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ir    <= '0;
            toCnt <= '0;
        end else begin
            state <= nextState;
            if (ir_write) ir <= bus.mem_rdata;
            if (nextState != state) toCnt <= '0;
            else if (memWait)       toCnt <= toCnt + TO_W'(1);
        end
    end

`ifdef PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (state != S_IDLE && state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
            if (retire)                             instr_cnt <= instr_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq: per-instruction expected traces built from the ISA timing
// rules, compared against the DUT every cycle, plus literal latency expectations.
module tb_multicycle_seq;
    localparam int TMO = 4;
    localparam int C_ILL = 0, C_B = 1, C_CBZ = 2, C_BC = 3, C_MOVZ = 4, C_CMP = 5,
                   C_SUBI = 6, C_ADD = 7, C_LDUR = 8, C_STUR = 9;

    typedef struct packed {
        logic [2:0] st;
        logic       req, we, asel, irw, pcw;
        logic [1:0] psrc;
        logic       r2l, asrc;
        logic [1:0] aop;
        logic       rw, m2r, fw, trp, ret;
    } outs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_zero = 1'b0, flag_cond = 1'b0;
    logic        ir_write, pc_write, Reg2Loc, ALUSrc, RegWrite, MemToReg, FlagWrite, trap, retire;
    logic [1:0]  pc_src, ALUOp;
    logic [2:0]  state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
    int          mCyc = 0, mIns = 0;
`endif

    multicycle_seq_if bus ();

    multicycle_seq #(.MEM_TIMEOUT(TMO), .TO_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .alu_zero(alu_zero), .flag_cond(flag_cond),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .FlagWrite(FlagWrite), .trap(trap), .retire(retire), .state(state)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    outs_t       dutOuts, expO;
    bit          expValid = 0;
    string       tag = "none";
    int          errors = 0, checks = 0;
    logic        curAz = 1'b0, curFc = 1'b0;

    assign dutOuts = '{st: state, req: bus.mem_req, we: bus.mem_we, asel: bus.addr_sel,
                       irw: ir_write, pcw: pc_write, psrc: pc_src, r2l: Reg2Loc, asrc: ALUSrc,
                       aop: ALUOp, rw: RegWrite, m2r: MemToReg, fw: FlagWrite, trp: trap,
                       ret: retire};

    always @(negedge clk) begin
        if (expValid) begin
            checks++;
            if (dutOuts !== expO) begin
                errors++;
                $display("FAIL %s @%0t: got %h want %h", tag, $time, dutOuts, expO);
            end
`ifdef PERF_CNT_EN
            if (expO.st == 3'd0) begin mCyc = 0; mIns = 0; end
            checks++;
            if (cycle_cnt !== 32'(mCyc) || instr_cnt !== 32'(mIns)) begin
                errors++;
                $display("FAIL perf %s: got cyc=%0d ins=%0d want cyc=%0d ins=%0d",
                         tag, cycle_cnt, instr_cnt, mCyc, mIns);
            end
            if (expO.st != 3'd0 && expO.st != 3'd6) mCyc++;
            if (expO.ret) mIns++;
`endif
        end
    end

    function automatic outs_t mk(input logic [2:0] s);
        outs_t o;
        o = '0;
        o.st = s;
        return o;
    endfunction

    function automatic int classify(input logic [31:0] w);
        if (w[31:24] == 8'hB4)           return C_CBZ;
        if (w[31:26] == 6'b000101)       return C_B;
        if (w[31:24] == 8'h54)           return C_BC;
        if (w[31:23] == 9'b110100101)    return C_MOVZ;
        if (w[31:24] == 8'hEB)           return C_CMP;
        if (w[31:23] == 9'b110100010)    return C_SUBI;
        if (w[31:21] == 11'b10001011000) return C_ADD;
        if (w[31:21] == 11'b11111000010) return C_LDUR;
        if (w[31:21] == 11'b11111000000) return C_STUR;
        return C_ILL;
    endfunction

    // One clock: inputs change just after the edge, outputs checked on the falling edge.
    task automatic step(input logic rdy, input outs_t e, input string nm);
        @(posedge clk); #1;
        bus.mem_ready = rdy;
        alu_zero      = curAz;
        flag_cond     = curFc;
        expO          = e;
        tag           = nm;
        expValid      = 1;
    endtask

    task automatic trapHold(input int n);
        outs_t e;
        e = mk(3'd6);
        e.trp = 1'b1;
        for (int i = 0; i < n; i++) step(1'b1, e, "trap");
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        rst_n = 1'b0; bus.mem_ready = 1'b0; expValid = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        expO = mk(3'd0); tag = "idle"; expValid = 1;
    endtask

    // Returns cycles from first FETCH to retire, or -1 for trap, -2 for an abandoned MEM.
    task automatic runInstr(input logic [31:0] w, input int fWait, input int mWait,
                            input logic az, input logic fc, input logic tie,
                            input int abortAt, output int lat);
        outs_t e;
        int    c;
        c = classify(w);
        bus.mem_rdata = w; curAz = az; curFc = fc;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            e = mk(3'd1); e.req = 1'b1;
            if (i == fWait) begin
                e.irw = 1'b1; e.pcw = 1'b1;
                step(1'b1, e, "fetch"); lat++;
                break;
            end
            step(1'b0, e, "fetchWait"); lat++;
            if (i + 1 == TMO) begin trapHold(3); lat = -1; return; end
        end
        e = mk(3'd2); e.r2l = (c == C_CBZ || c == C_STUR);
        step(tie, e, "decode"); lat++;
        if (c == C_ILL) begin trapHold(20); lat = -1; return; end
        e = mk(3'd3);
        case (c)
            C_B:    begin e.pcw = 1'b1; e.psrc = 2'b01; e.ret = 1'b1; end
            C_CBZ:  begin e.aop = 2'b01; e.r2l = 1'b1; e.pcw = az; e.psrc = 2'b01; e.ret = 1'b1; end
            C_BC:   begin e.pcw = fc; e.psrc = 2'b01; e.ret = 1'b1; end
            C_CMP:  begin e.aop = 2'b01; e.fw = 1'b1; e.ret = 1'b1; end
            C_ADD:  e.aop = 2'b10;
            C_SUBI: begin e.aop = 2'b10; e.asrc = 1'b1; end
            default: e.asrc = 1'b1;
        endcase
        step(tie, e, "exec"); lat++;
        if (e.ret) return;
        if (c == C_LDUR || c == C_STUR) begin
            for (int i = 0; i < 100; i++) begin
                e = mk(3'd4); e.req = 1'b1; e.asel = 1'b1; e.we = (c == C_STUR);
                if (i == abortAt) begin lat = -2; return; end
                if (i == mWait) begin
                    e.ret = (c == C_STUR);
                    step(1'b1, e, "mem"); lat++;
                    break;
                end
                step(1'b0, e, "memWait"); lat++;
                if (i + 1 == TMO) begin trapHold(3); lat = -1; return; end
            end
            if (c == C_STUR) return;
        end
        e = mk(3'd5); e.rw = 1'b1; e.m2r = (c == C_LDUR); e.ret = 1'b1;
        step(tie, e, "wb"); lat++;
    endtask

    task automatic checkLat(input int got, input int want, input string nm);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL latency %s: got %0d want %0d", nm, got, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        doReset();
        runInstr(32'h14000004, 0, 0, 1'b0, 1'b0, 1'b1, -1, lat); checkLat(lat, 3, "B");
        runInstr(32'hF8400020, 0, 3, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 8, "LDUR wait3");
        runInstr(32'hB4000040, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 3, "CBZ nz");
        runInstr(32'hB4000040, 0, 0, 1'b1, 1'b0, 1'b0, -1, lat); checkLat(lat, 3, "CBZ z");
        runInstr(32'h54000040, 0, 0, 1'b0, 1'b1, 1'b1, -1, lat); checkLat(lat, 3, "Bcond t");
        runInstr(32'h54000040, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 3, "Bcond f");
        runInstr(32'hEB01001F, 0, 0, 1'b1, 1'b1, 1'b0, -1, lat); checkLat(lat, 3, "CMP");
        runInstr(32'h8B020020, 0, 0, 1'b0, 1'b0, 1'b1, -1, lat); checkLat(lat, 4, "ADD");
        runInstr(32'hD1000420, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 4, "SUBI");
        runInstr(32'hD2800020, 0, 0, 1'b0, 1'b0, 1'b1, -1, lat); checkLat(lat, 4, "MOVZ");
        runInstr(32'hF8000020, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 4, "STUR");
        runInstr(32'hF8400020, 0, 0, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 5, "LDUR");
        runInstr(32'h14000004, 3, 0, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 6, "fetch ready@4");
        runInstr(32'h00000000, 0, 0, 1'b0, 1'b0, 1'b1, -1, lat); checkLat(lat, -1, "illegal");
        doReset();
        runInstr(32'h14000004, 99, 0, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, -1, "fetch timeout");
        doReset();
        runInstr(32'hF8400020, 0, 99, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, -1, "mem timeout");
        doReset();
        runInstr(32'hF8000020, 0, 99, 1'b0, 1'b0, 1'b0, 1, lat); checkLat(lat, -2, "STUR abort");
        doReset();
        runInstr(32'hF8000020, 1, 2, 1'b0, 1'b0, 1'b0, -1, lat); checkLat(lat, 7, "STUR waits");
        @(posedge clk); #1;
        expValid = 0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
